// File: rtl/fll_cfg_pkg.sv
// FLL configuration controller shared types.
// FSM states, register indices and STATUS bit positions.
package fll_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL,
    ST_DONE
  } state_t;

  localparam logic [2:0] REG_FLL0   = 3'd0;
  localparam logic [2:0] REG_FLL1   = 3'd1;
  localparam logic [2:0] REG_FLL2   = 3'd2;
  localparam logic [2:0] REG_FLL3   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int STAT_LOCK  = 0;
  localparam int STAT_TOERR = 1;

endpackage

// File: rtl/fll_cfg_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
// Reset clears both stages.
module fll_cfg_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // shift the async input through two flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fll_cfg_ctrl.sv
// APB slave bridging to the FLL 4-phase config port.
// Local STATUS register, per-state handshake timeout.
module fll_cfg_ctrl
  import fll_cfg_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      fll_req_o,
  output logic                      fll_wrn_o,
  output logic [1:0]                fll_add_o,
  output logic [31:0]               fll_data_o,
  input  logic                      fll_ack_i,
  input  logic [31:0]               fll_r_data_i,
  input  logic                      fll_lock_i
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ack_s;
  logic          lock_s;
  logic          err_q;
  logic          drop_q;
  logic          to_err;
  logic [31:0]   rdata_q;
  logic [31:0]   stat_word;

  logic       access;
  logic [2:0] idx;
  logic       hi_bad;
  logic       is_fll;
  logic       is_stat;
  logic       is_bad;
  logic       in_idle;
  logic       in_done;
  logic       to_hit;
  logic       stat_clr;
  logic       unused_addr;

  fll_cfg_sync u_ack_sync (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (fll_ack_i),
    .q     (ack_s)
  );

  fll_cfg_sync u_lock_sync (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (fll_lock_i),
    .q     (lock_s)
  );

  assign unused_addr = ^paddr_i[1:0];

  assign access  = psel_i & penable_i;
  assign idx     = paddr_i[4:2];
  assign hi_bad  = |paddr_i[APB_ADDR_WIDTH-1:5];
  assign is_fll  = ~hi_bad & (idx <= REG_FLL3);
  assign is_stat = ~hi_bad & (idx == REG_STATUS);
  assign is_bad  = ~is_fll & ~is_stat;
  assign in_idle = (state == ST_IDLE);
  assign in_done = (state == ST_DONE);

  // a wait state expires on its last allowed cycle
  assign to_hit = (cnt == LAST) &
                  (((state == ST_REQ) & ~ack_s) |
                   ((state == ST_REL) &  ack_s));

  assign stat_clr = in_idle & access & is_stat &
                    pwrite_i & pwdata_i[STAT_TOERR];

  // STATUS word assembled from synced lock and sticky error
  always_comb begin
    stat_word             = '0;
    stat_word[STAT_LOCK]  = lock_s;
    stat_word[STAT_TOERR] = to_err;
  end

  // APB response: local accesses complete in IDLE, FLL ones in DONE
  always_comb begin
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = rdata_q;
    if (access && in_idle && !is_fll) begin
      pready_o  = 1'b1;
      pslverr_o = is_bad;
      prdata_o  = is_stat ? stat_word : '0;
    end else if (access && in_done && !drop_q) begin
      pready_o  = 1'b1;
      pslverr_o = err_q;
    end
  end

  // sticky timeout flag; a timeout set beats a STATUS clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_err <= 1'b0;
    end else if (to_hit) begin
      to_err <= 1'b1;
    end else if (stat_clr) begin
      to_err <= 1'b0;
    end
  end

  // handshake FSM with registered FLL outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      rdata_q    <= '0;
      fll_req_o  <= 1'b0;
      fll_wrn_o  <= 1'b1;
      fll_add_o  <= '0;
      fll_data_o <= '0;
    end else begin
      if ((state == ST_REQ || state == ST_REL) && !access) begin
        drop_q <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (access && is_fll && !ack_s) begin
            state      <= ST_REQ;
            cnt        <= '0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            fll_req_o  <= 1'b1;
            fll_wrn_o  <= ~pwrite_i;
            fll_add_o  <= idx[1:0];
            fll_data_o <= pwdata_i;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            if (fll_wrn_o) begin
              rdata_q <= fll_r_data_i;
            end
            fll_req_o <= 1'b0;
            cnt       <= '0;
            state     <= ST_REL;
          end else if (to_hit) begin
            fll_req_o <= 1'b0;
            err_q     <= 1'b1;
            rdata_q   <= '0;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REL: begin
          if (!ack_s) begin
            state <= ST_DONE;
          end else if (to_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fll_cfg_ctrl.md
FLL_CFG_CTRL -- requirements
Module: fll_cfg_ctrl

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, the maximum number of cycles spent in each handshake wait state.
REQ-003 SHALL have one clock and an asynchronous active-low reset; ports are listed in REQ-004 to REQ-020.
REQ-004 clk_i  in  1  single clock.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 paddr_i  in  APB_ADDR_WIDTH  APB address.
REQ-007 pwdata_i  in  32  APB write data.
REQ-008 pwrite_i  in  1  APB write (1) / read (0).
REQ-009 psel_i  in  1  APB select.
REQ-010 penable_i  in  1  APB enable.
REQ-011 prdata_o  out  32  APB read data.
REQ-012 pready_o  out  1  APB ready.
REQ-013 pslverr_o  out  1  APB error.
REQ-014 fll_req_o  out  1  FLL config request, 4-phase.
REQ-015 fll_wrn_o  out  1  FLL write-not (1 = read).
REQ-016 fll_add_o  out  2  FLL register address.
REQ-017 fll_data_o  out  32  FLL write data.
REQ-018 fll_ack_i  in  1  FLL acknowledge; asynchronous to clk_i.
REQ-019 fll_r_data_i  in  32  FLL read data; stable while ack is high.
REQ-020 fll_lock_i  in  1  FLL lock; asynchronous to clk_i.

Function
REQ-021 SHALL decode paddr_i[4:2]: 0-3 = FLL register, passed to fll_add_o; 4 = STATUS (local); 5-7 and any nonzero paddr_i above bit 4 = invalid.
REQ-022 SHALL double-flop fll_ack_i into ack_s and fll_lock_i into lock_s before any use.
REQ-023 SHALL implement the FSM states IDLE, REQ, REL and DONE.
REQ-024 IDLE -> REQ on psel_i & penable_i with an FLL address; in the same edge, register fll_wrn_o = ~pwrite_i, fll_add_o and fll_data_o = pwdata_i, and set fll_req_o = 1.
REQ-025 In REQ: hold fll_req_o, fll_wrn_o, fll_add_o and fll_data_o stable; when ack_s = 1, capture fll_r_data_i into prdata_o if reading, clear fll_req_o and go to REL.
REQ-026 In REL: keep fll_req_o = 0; when ack_s = 0, go to DONE.
REQ-027 In DONE: assert pready_o for exactly one cycle and return to IDLE.
REQ-028 A new request SHALL NOT be issued until ack_s has returned low (full 4-phase handshake).
REQ-029 Each REQ and REL stay SHALL be limited by a counter that restarts on state entry.
REQ-030 When that counter reaches TIMEOUT_CYC: set fll_req_o = 0, set the sticky flag to_err, go to DONE, and assert pslverr_o together with pready_o; prdata_o = 0 on a timed-out read.
REQ-031 STATUS and invalid accesses SHALL complete with zero wait states: pready_o = 1 combinationally during the access phase while in IDLE.
REQ-032 Invalid accesses SHALL also set pslverr_o = 1 with prdata_o = 0.
REQ-033 A STATUS read SHALL return {30'b0, to_err, lock_s}.
REQ-034 A STATUS write with pwdata_i[1] = 1 SHALL clear to_err; the clear loses to a same-cycle timeout set.
REQ-035 If psel_i drops during REQ or REL (APB violation), the handshake SHALL still complete and the result is discarded; pready_o is not asserted without psel_i & penable_i.
REQ-036 Minimum FLL access latency (ack responding immediately) SHALL be access phase + 1 (REQ) + 2 (sync) + 1 (REL) + 2 (sync) + DONE.

Reset
REQ-037 On reset assertion, asynchronously: FSM = IDLE, fll_req_o = 0, fll_wrn_o = 1, fll_add_o = 0, fll_data_o = 0, prdata_o = 0, pready_o = 0, pslverr_o = 0, to_err = 0, synchronizers = 0, counter = 0.
REQ-038 Reset mid-handshake SHALL drop fll_req_o immediately; the responder is expected to release ack on its own.

Structure
REQ-039 Package fll_cfg_pkg SHALL hold the FSM state enum, the register index constants (FLL0-3 = 0-3, STATUS = 4) and the STATUS bit positions.
REQ-040 The two-flop synchronizer SHALL be sub-module fll_cfg_sync (1-bit, parameterless), instantiated twice.

Verification
REQ-041 Write addr 0x08, data 0xDEADBEEF, with the responder acking after 3 cycles -> fll_add_o = 2, fll_wrn_o = 0, data stable until ack_s; one pready_o pulse, pslverr_o = 0.
REQ-042 Read addr 0x04 with responder data 0x12345678 -> prdata_o = 0x12345678 at pready_o; next request issued only after ack has been seen low.
REQ-043 Read addr 0x00 with ack never asserted -> after TIMEOUT_CYC cycles, pready_o = 1, pslverr_o = 1, fll_req_o = 0; STATUS read = 0x2 (lock low).
REQ-044 After REQ-043, write STATUS 0x2 -> STATUS read = 0x0; fll_lock_i = 1 -> STATUS = 0x1 within 2 cycles plus the read.
REQ-045 Access 0x18 -> zero-wait pready_o = 1 with pslverr_o = 1; no fll_req_o activity.
REQ-046 Assert rst_ni low while in REQ -> fll_req_o = 0 asynchronously, all outputs at reset values, next access behaves normally.
